// File: rtl/tpu_seq_pkg.sv
// Purpose: shared state encoding, tpuv1 address map and address helpers for the job sequencer.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
package tpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR_C,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        READ_C,
        DONE
    } seq_state_t;

    localparam int unsigned A_BASE     = 32'h100;
    localparam int unsigned B_BASE     = 32'h200;
    localparam int unsigned C_BASE     = 32'h300;
    localparam int unsigned START_ADDR = 32'h400;
    localparam int unsigned A_STRIDE   = 8;
    localparam int unsigned C_STRIDE   = 16;
    localparam int unsigned C_HI_OFF   = 8;

    // A row address for a given row index.
    function automatic int unsigned a_addr(input int unsigned row);
        return A_BASE + A_STRIDE * row;
    endfunction

    // C half-row address: bit 0 picks low/high half, the rest picks the row.
    function automatic int unsigned c_addr(input int unsigned idx);
        return C_BASE + C_STRIDE * (idx >> 1) + (((idx & 1) != 0) ? C_HI_OFF : 0);
    endfunction

endpackage

// File: rtl/tpu_job_sequencer.sv
// Purpose: runs one full matmul job on the tpuv1 bus (clear C, load A/B, start, wait, read C).
// Latency: bus outputs are combinational; job takes 82 cycles with clear, 66 with accum (DIM=8, no stalls).
// Backpressure: operand bubbles and result-sink stalls freeze the row counter and hold the bus address.
module tpu_job_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int DIM      = 8,
    parameter int ADDRW    = 16,
    parameter int DATAW    = 64,
    parameter int WAIT_CYC = 4 * DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    input  logic             job_accum,
    output logic             job_ready,
    input  logic             op_valid,
    input  logic [DATAW-1:0] op_data,
    output logic             op_ready,
    output logic             res_valid,
    output logic [DATAW-1:0] res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);

    localparam int IW = $clog2(2 * DIM);
    localparam int WW = $clog2(WAIT_CYC + 1);

    localparam logic [IW-1:0] ROW_LAST  = IW'(DIM - 1);
    localparam logic [IW-1:0] HALF_LAST = IW'(2 * DIM - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

    seq_state_t    state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;

    // State and counter registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state, counter update and all bus/stream outputs.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        wcnt_nxt   = wcnt;
        job_ready  = 1'b0;
        op_ready   = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        busy       = 1'b1;
        done       = 1'b0;
        tpu_r_w    = 1'b0;
        tpu_addr   = '0;
        tpu_dataIn = '0;

        case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) begin
                    state_nxt = job_accum ? LOAD_A : CLEAR_C;
                    idx_nxt   = '0;
                end
            end

            CLEAR_C: begin
                tpu_r_w  = 1'b1;
                tpu_addr = ADDRW'(c_addr(32'(idx)));
                if (idx == HALF_LAST) begin
                    state_nxt = LOAD_A;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end

            LOAD_A: begin
                op_ready   = 1'b1;
                tpu_r_w    = op_valid;
                tpu_addr   = ADDRW'(a_addr(32'(idx)));
                tpu_dataIn = op_data;
                if (op_valid) begin
                    if (idx == ROW_LAST) begin
                        state_nxt = LOAD_B;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end

            LOAD_B: begin
                op_ready   = 1'b1;
                tpu_r_w    = op_valid;
                tpu_addr   = ADDRW'(B_BASE);
                tpu_dataIn = op_data;
                if (op_valid) begin
                    if (idx == ROW_LAST) begin
                        state_nxt = START;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end

            START: begin
                tpu_r_w   = 1'b1;
                tpu_addr  = ADDRW'(START_ADDR);
                wcnt_nxt  = '0;
                state_nxt = WAIT;
            end

            WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    state_nxt = READ_C;
                    idx_nxt   = '0;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end

            READ_C: begin
                tpu_addr  = ADDRW'(c_addr(32'(idx)));
                res_valid = 1'b1;
                res_data  = tpu_dataOut;
                if (res_ready) begin
                    if (idx == HALF_LAST) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
module tb_tpu_job_sequencer;

    localparam int DIM   = 8;
    localparam int ADDRW = 16;
    localparam int DATAW = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             job_valid, job_accum, job_ready;
    logic             op_valid, op_ready;
    logic [DATAW-1:0] op_data;
    logic             res_valid, res_ready;
    logic [DATAW-1:0] res_data;
    logic             busy, done;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn, tpu_dataOut;

    int errors = 0;
    int total  = 0;

    tpu_job_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_accum(job_accum), .job_ready(job_ready),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .done(done),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn),
        .tpu_dataOut(tpu_dataOut)
    );

    always #5 clk = ~clk;

    // Behavioural TPU: stores A rows and shifted-in B rows, C += A*B on start.
    logic [7:0]  ta [DIM][DIM];
    logic [7:0]  tbm[DIM][DIM];
    logic [15:0] tc [DIM][DIM];
    int          bcnt;

    function automatic logic [15:0] mac(input int r, input int j);
        logic [15:0] s = '0;
        for (int k = 0; k < DIM; k++) s = s + 16'(ta[r][k]) * 16'(tbm[k][j]);
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++)
                for (int j = 0; j < DIM; j++) tc[r][j] <= '0;
            bcnt <= 0;
        end else if (tpu_r_w) begin
            if (tpu_addr[15:8] == 8'h01) begin
                for (int k = 0; k < DIM; k++) ta[tpu_addr[5:3]][k] <= tpu_dataIn[8*k +: 8];
            end else if (tpu_addr == 16'h0200) begin
                for (int k = 0; k < DIM; k++) tbm[bcnt%DIM][k] <= tpu_dataIn[8*k +: 8];
                bcnt <= bcnt + 1;
            end else if (tpu_addr[15:8] == 8'h03) begin
                for (int j = 0; j < DIM/2; j++)
                    tc[tpu_addr[6:4]][int'(tpu_addr[3])*(DIM/2)+j] <= tpu_dataIn[16*j +: 16];
            end else if (tpu_addr == 16'h0400) begin
                for (int r = 0; r < DIM; r++)
                    for (int j = 0; j < DIM; j++) tc[r][j] <= tc[r][j] + mac(r, j);
                bcnt <= 0;
            end
        end
    end

    always_comb begin
        tpu_dataOut = '0;
        if (tpu_addr[15:8] == 8'h03)
            for (int j = 0; j < DIM/2; j++)
                tpu_dataOut[16*j +: 16] = tc[tpu_addr[6:4]][int'(tpu_addr[3])*(DIM/2)+j];
    end

    // Reference model: operands the bench sends and the C matrix it expects.
    logic [7:0]  op_a[DIM][DIM];
    logic [7:0]  op_b[DIM][DIM];
    int          exp_c[DIM][DIM];
    logic [79:0] wlog[$];
    logic [63:0] first_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] a_row(input int r);
        logic [63:0] v;
        for (int k = 0; k < DIM; k++) v[8*k +: 8] = op_a[r][k];
        return v;
    endfunction

    function automatic logic [63:0] b_row(input int k);
        logic [63:0] v;
        for (int j = 0; j < DIM; j++) v[8*j +: 8] = op_b[k][j];
        return v;
    endfunction

    function automatic logic [63:0] exp_beat(input int b);
        logic [63:0] v;
        for (int j = 0; j < DIM/2; j++) v[16*j +: 16] = 16'(exp_c[b/2][(b%2)*(DIM/2)+j]);
        return v;
    endfunction

    function automatic logic [15:0] exp_caddr(input int b);
        return 16'(16'h300 + 16*(b/2) + 8*(b%2));
    endfunction

    task automatic set_directed();
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                op_a[r][k] = (r == k) ? 8'd1 : 8'd0;
                op_b[r][k] = 8'(r + 1);
            end
    endtask

    task automatic set_random();
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                op_a[r][k] = 8'($urandom);
                op_b[r][k] = 8'($urandom);
            end
    endtask

    task automatic clear_ref();
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) exp_c[r][j] = 0;
    endtask

    task automatic run_job(input bit accum, input bit bubbles, input int stall_beat,
                           input int stall_len, input bit hold);
        int          cyc, op_ptr, res_ptr, stall_rem, exp_lat, ne, s;
        bit          gap, fin;
        logic [15:0] ea[2*DIM+2*DIM+1];
        logic [63:0] ed[2*DIM+2*DIM+1];

        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) s += int'(op_a[r][k]) * int'(op_b[k][j]);
                exp_c[r][j] = ((accum ? exp_c[r][j] : 0) + s) & 32'hFFFF;
            end
        exp_lat = (accum ? 66 : 82) + (bubbles ? 2*DIM-1 : 0) + (stall_beat >= 0 ? stall_len : 0);
        wlog.delete();

        @(negedge clk);
        job_valid = 1'b1; job_accum = accum; op_valid = 1'b0; res_ready = 1'b1;
        #1;
        check("job_ready_idle", job_ready, 1'b1);
        @(negedge clk);
        if (!hold) job_valid = 1'b0;

        cyc = 1; op_ptr = 0; res_ptr = 0; gap = 0; fin = 0; stall_rem = stall_len;
        while (!fin && cyc < 400) begin
            op_valid  = (op_ptr < 2*DIM) && !gap;
            op_data   = (op_ptr < DIM) ? a_row(op_ptr) : b_row(op_ptr % DIM);
            res_ready = !(res_ptr == stall_beat && stall_rem > 0);
            #1;
            check("job_ready_busy", job_ready, 1'b0);
            if (tpu_r_w) wlog.push_back({tpu_addr, tpu_dataIn});
            if (op_valid && op_ready) begin
                op_ptr++;
                gap = bubbles;
            end else begin
                gap = 0;
            end
            if (res_valid) begin
                check("res_addr", tpu_addr, exp_caddr(res_ptr));
                check("res_data", res_data, exp_beat(res_ptr));
                if (res_ready) begin
                    if (res_ptr == 0) first_beat = res_data;
                    res_ptr++;
                end else begin
                    stall_rem--;
                end
            end
            if (done) begin
                fin = 1;
                check("done_latency", cyc, exp_lat);
                check("busy_in_done", busy, 1'b1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", fin, 1'b1);
        check("res_beats", res_ptr, 2*DIM);
        check("op_beats", op_ptr, 2*DIM);

        ne = 0;
        if (!accum)
            for (int i = 0; i < 2*DIM; i++) begin ea[ne] = exp_caddr(i); ed[ne] = '0; ne++; end
        for (int r = 0; r < DIM; r++) begin ea[ne] = 16'(16'h100 + 8*r); ed[ne] = a_row(r); ne++; end
        for (int k = 0; k < DIM; k++) begin ea[ne] = 16'h200; ed[ne] = b_row(k); ne++; end
        ea[ne] = 16'h400; ed[ne] = '0; ne++;
        check("wr_count", wlog.size(), ne);
        for (int i = 0; i < ne && i < wlog.size(); i++) begin
            check("wr_addr", wlog[i][79:64], ea[i]);
            if (i != ne - 1) check("wr_data", wlog[i][63:0], ed[i]);
        end
    endtask

    initial begin
        int hs;
        rst_n = 1'b0; job_valid = 1'b0; job_accum = 1'b0;
        op_valid = 1'b0; op_data = '0; res_ready = 1'b1;
        clear_ref();
        #12;
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_op_ready", op_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_r_w", tpu_r_w, 1'b0);
        check("rst_addr", tpu_addr, 16'h0);
        check("rst_dataIn", tpu_dataIn, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Operand beats outside a load state are not consumed or written.
        @(negedge clk);
        op_valid = 1'b1; op_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("idle_op_ready", op_ready, 1'b0);
        check("idle_r_w", tpu_r_w, 1'b0);
        op_valid = 1'b0;

        // Reset in LOAD_A after three accepted rows aborts straight to IDLE.
        set_random();
        @(negedge clk);
        job_valid = 1'b1; job_accum = 1'b1;
        @(negedge clk);
        job_valid = 1'b0; hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            op_valid = 1'b1; op_data = a_row(hs);
            #1;
            if (op_ready) hs++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        check("pre_rst_beats", hs, 3);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_job_ready", job_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_r_w", tpu_r_w, 1'b0);
        check("mid_rst_addr", tpu_addr, 16'h0);
        check("mid_rst_op_ready", op_ready, 1'b0);
        clear_ref();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed identity x (k+1) job, clean flow.
        set_directed();
        run_job(1'b0, 1'b0, -1, 0, 1'b0);
        check("dir_first_beat", first_beat, 64'h0001_0001_0001_0001);
        // Same job with a bubble after every accepted operand.
        run_job(1'b0, 1'b1, -1, 0, 1'b0);
        // Result sink stalls 5 cycles at beat 3 (address 0x318).
        run_job(1'b0, 1'b0, 3, 5, 1'b0);
        // Accumulate onto the previous result: every element doubles.
        run_job(1'b1, 1'b0, -1, 0, 1'b0);
        check("acc_first_beat", first_beat, 64'h0002_0002_0002_0002);
        // job_valid held high through the job; the next job is the next IDLE visit.
        set_random();
        run_job(1'b0, 1'b0, -1, 0, 1'b1);
        // Randomized jobs.
        for (int n = 0; n < 4; n++) begin
            set_random();
            run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2*DIM-1), $urandom_range(1, 6), 1'b0);
        end
        @(negedge clk);
        job_valid = 1'b0;
        #1;
        check("end_idle_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule

// File: doc/tpu_job_sequencer.md
Name: tpu_job_sequencer

Overview:
Host-side controller that runs one complete matrix-multiply job on the tpuv1 bus (r_w/addr/dataIn/dataOut) without host micro-management. It accepts a job request, optionally clears the C accumulators, and streams DIM A rows and DIM B rows from an operand stream into the TPU. It then issues the start write, waits out the compute window, and streams the 2*DIM C half-words to a result stream. It sits between the host stream fabric and the tpuv1 top.

Parameters:
DIM, 8, systolic array dimension; power of two.
ADDRW, 16, TPU bus address width.
DATAW, 64, TPU bus data width.
WAIT_CYC, 4*DIM, cycles held in WAIT after the start write; must be ≥ 4*DIM-1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job request
job_accum  in  1  1 = keep existing C (skip clear); sampled on job handshake
job_ready  out  1  high only in IDLE
op_valid  in  1  operand beat valid
op_data  in  DATAW  operand beat (one A or B row)
op_ready  out  1  high only in LOAD_A/LOAD_B
res_valid  out  1  result beat valid
res_data  out  DATAW  result beat (C half-row)
res_ready  in  1  result sink ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
tpu_r_w  out  1  TPU bus write strobe
tpu_addr  out  ADDRW  TPU bus address
tpu_dataIn  out  DATAW  TPU bus write data
tpu_dataOut  in  DATAW  TPU bus read data (combinational from tpu_addr)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters=0, job_ready=1, busy=0, done=0, op_ready=0, res_valid=0, tpu_r_w=0, tpu_addr=0, tpu_dataIn=0. Reset mid-job aborts immediately with no drain. The TPU shares rst_n.
- Address map: A row r = 0x100+8r; B = 0x200; C row r low = 0x300+16r; C row r high = 0x308+16r; start = 0x400.
- Bus outputs are combinational from state, counters and handshakes. No added latency. The TPU samples writes on the next posedge.
- IDLE: job_valid&&job_ready → latch job_accum. Next state is CLEAR_C if job_accum=0, else LOAD_A. Counter idx=0.
- CLEAR_C: one write per cycle, 2*DIM cycles. tpu_r_w=1, tpu_dataIn=0, addr idx[0] selects low/high, idx[..:1] selects row. Order: r0 lo, r0 hi, r1 lo, ... → LOAD_A.
- LOAD_A: op_ready=1. tpu_r_w=op_valid, tpu_addr=0x100+8*idx, tpu_dataIn=op_data. idx advances only on op handshake; a bubble leaves r_w=0. After DIM beats → LOAD_B, idx=0.
- LOAD_B: same handshake rule. tpu_addr=0x200, DIM beats, beat k = B row k in TPU shift order → START.
- START: one cycle, tpu_r_w=1, tpu_addr=0x400 → WAIT, wait counter=0.
- WAIT: no bus activity (r_w=0, addr=0). Count WAIT_CYC cycles → READ_C, idx=0.
- READ_C: tpu_r_w=0, tpu_addr = C address for idx (same order as CLEAR_C). res_valid=1, res_data=tpu_dataOut. idx advances on res_valid&&res_ready. While stalled, addr is held. After 2*DIM beats → DONE.
- DONE: done=1 for one cycle → IDLE. busy is still 1 in DONE.
- Result beat layout: bits [16j+15:16j] = C[row][j] (low beat) or C[row][j+DIM/2] (high beat).
- Job latency, no stalls, DIM=8, WAIT_CYC=32, from the cycle after the job handshake to the done pulse: 82 cycles with clear, 66 with accum.
- job_valid is ignored while busy. op_valid is ignored outside load states. Surplus operand beats remain unconsumed for the next job.
- Counter widths: idx is $clog2(2*DIM) bits; the wait counter is $clog2(WAIT_CYC+1) bits. Neither counter wraps within a state.

Decomposition:
- Package tpu_seq_pkg:
  - state enum {IDLE, CLEAR_C, LOAD_A, LOAD_B, START, WAIT, READ_C, DONE}
  - constants A_BASE=0x100, B_BASE=0x200, C_BASE=0x300, START_ADDR=0x400, A_STRIDE=8, C_STRIDE=16, C_HI_OFF=8
- Single module; no sub-module needed. The address generator is a small combinational function in the package.

Test Plan:
1. Reset during LOAD_A after 3 beats → next cycle state IDLE, job_ready=1, busy=0, tpu_r_w=0, tpu_addr=0.
2. Job (accum=0) with A=identity, B row k = all bytes (k+1), no stalls → CLEAR writes 0x300..0x378 with data 0. Done at cycle 82. Result beats: row r low = {16'(r+1)}×4, high identical.
3. Same job with op_valid deasserted every other cycle → no bus write in bubble cycles. A addresses stay 0x100,0x108,...,0x138 in order. Results unchanged. Done is delayed by exactly the bubble count.
4. res_ready low for 5 cycles at beat 3 → tpu_addr held at 0x318, res_data stable, no beat lost or duplicated. 16 beats total.
5. Second job with job_accum=1, same operands → no CLEAR writes. Every C element equals 2× its value in scenario 2. Latency 66 cycles.
6. job_valid held high through the whole job → only one job accepted per IDLE visit. job_ready=0 from job accept through DONE.
